sudoku_group_pruner: RTL and testbench
======================================

Name: sudoku_group_pruner

Overview:
- Initiator-side engine for the cell register interface (per-cell wdata/rdata/address/we).
- Run once per group (one row, column or box of 9 cells). Reads every cell's committed value (address 0), builds the set of digits used in the group, then writes the complement as a constraint mask to every cell's candidate register (address 1).
- Flags groups with duplicate or malformed values.
- Sits between the puzzle scheduler (start/done) and a 9:1 muxed cell bus.

Parameters:
- N_CELLS, 9, cells per group; fixed at 9 for sudoku, a parameter only for bench scaling.
- IDX_W, 4, width of cell_sel; must satisfy 2**IDX_W >= N_CELLS.
- WRITE_SOLVED, 1: 1 = write the mask to every cell; 0 = suppress cell_we for cells whose read value was nonzero. Cycle count is unchanged either way.

Ports:
- clk  input  1  clock.
- reset_n  input  1  synchronous reset, active-low.
- start  input  1  one-cycle request to prune the currently attached group.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at the end of a run.
- conflict  output  1  valid with done and held until the next accepted start: duplicate or non-one-hot value found.
- used_mask  output  [9:1]  OR of all values read; valid with done and held until the next accepted start.
- cell_sel  output  IDX_W  index of the addressed cell (0..N_CELLS-1).
- cell_address  output  1  0 = value register, 1 = candidate register.
- cell_we  output  1  write strobe to the selected cell.
- cell_wdata  output  [9:1]  write data.
- cell_rdata  input  [9:1]  combinational read from the selected cell at cell_address.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; busy, done, conflict, cell_we, cell_address = 0; cell_sel=0; used_mask=0; cell_wdata=0.
- All outputs are registered or decoded from registered state only. No combinational path from cell_rdata or start to any output.
- States: IDLE, READ, WRITE, FIN.
- IDLE:
  - start=1 → READ next cycle.
  - On that edge: idx=0, seen=0, bad=0, conflict=0, used_mask=0.
  - start while busy or in FIN is ignored and is not queued.
- READ (N_CELLS cycles, idx 0..8):
  - cell_address=0, cell_we=0, cell_sel=idx.
  - cell_rdata is sampled at the clock edge ending each cycle.
  - Per sample v: if v != 0 and (v has more than one bit set, or (v & seen) != 0) then bad <= 1. seen <= seen | v.
  - Record solved[idx] = (v != 0) for WRITE_SOLVED=0.
  - After idx=8:
    - bad (including a bad detected on the final sample) → FIN; no write is issued.
    - otherwise → WRITE with idx=0.
- WRITE (N_CELLS cycles):
  - cell_address=1, cell_wdata=~seen (9 bits), cell_sel=idx.
  - cell_we=1, except cell_we=0 when WRITE_SOLVED=0 and solved[idx].
  - Last write at idx=8 → FIN.
- FIN (1 cycle): done=1, busy=0, conflict=bad, used_mask=seen. Then → IDLE.
- Latency: start at cycle 0 → done at cycle 19 (clean run) or cycle 10 (conflict).
- busy is 1 in READ and WRITE, 0 in IDLE and FIN.
- idx is a counter; it never exceeds N_CELLS-1 and does not wrap within a phase.
- seen=0 (empty group) → mask 0x1FF is written to all cells. This is legal.
- seen=0x1FF → mask 0 is written. Cells with a nonzero value are unaffected (they force their own candidates to 0).
- Reset mid-run: cell_we is 0 from the next edge and the run is abandoned. Cells may hold partial masks; the scheduler re-runs the group.
- Cell contents changed by other masters during a run are not detected. The scheduler owns bus arbitration.

Decomposition:
- Shared package: state encoding (IDLE/READ/WRITE/FIN), CELL_ADDR_VALUE=0, CELL_ADDR_VALID=1, DIGIT_MASK_ALL=9'h1FF, digit width 9.
- Natural sub-module: sudoku_onehot_check. Combinational; gives is_zero and is_onehot for a [9:1] value. The team's existing cells need the same popcount logic.

Test Plan:
- Row values 1,0,3,0,0,0,0,0,9 (one-hot masks 0x001,0,0x004,…,0x100); start → 9 reads at address 0, then 9 writes of cell_wdata=0x0FA at address 1; done at cycle 19; used_mask=0x105, conflict=0.
- Duplicate: cells 2 and 7 both 0x010 → no cell_we ever asserted; done at cycle 10 with conflict=1, used_mask=0x010.
- Malformed value 0x003 in cell 8 (last read) → conflict=1, done at cycle 10, no writes.
- All cells 0 → 9 writes of 0x1FF; used_mask=0, conflict=0. With WRITE_SOLVED=0 and cell 4 = 0x020: cell_we is low only at idx 4, and data is 0x1DF.
- start pulsed during READ and during FIN → ignored; exactly one done per accepted start.
- reset_n low during WRITE at idx 3 → next cycle state is IDLE, cell_we=0, busy=0, done=0. A new start then completes a normal 19-cycle run.

Source files
------------

// File: rtl/sudoku_group_pruner_pkg.sv
// Shared definitions for the sudoku group pruner and the cell helpers.
// Contents:
//   - FSM state encodings (IDLE/READ/WRITE/FIN).
//   - Cell register address constants.
//   - Digit mask width and the all-digits mask.
//   - digit_popcount: counts the set digit bits of a [9:1] value.
package sudoku_group_pruner_pkg;

    localparam int DIGIT_W = 9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam logic CELL_ADDR_VALUE = 1'b0;
    localparam logic CELL_ADDR_VALID = 1'b1;

    localparam logic [DIGIT_W-1:0] DIGIT_MASK_ALL = 9'h1FF;

    function automatic logic [3:0] digit_popcount(input logic [9:1] value);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            cnt = cnt + {3'd0, value[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sudoku_onehot_check.sv
// Combinational classifier for a cell digit value.
// Ports:
//   value_i     [9:1]  digit mask (bit d set = digit d)
//   is_zero_o          no digit set (unsolved cell)
//   is_onehot_o        exactly one digit set (well-formed solved cell)
module sudoku_onehot_check
    import sudoku_group_pruner_pkg::*;
(
    input  logic [9:1] value_i,
    output logic       is_zero_o,
    output logic       is_onehot_o
);

    assign is_zero_o   = (value_i == 9'd0);
    assign is_onehot_o = (digit_popcount(value_i) == 4'd1);

endmodule

// File: rtl/sudoku_group_pruner.sv
// Prunes one sudoku group (row, column or box): reads every cell's committed
// value, collects the used digits and writes the complement to every cell's
// candidate register. Groups holding a duplicate or malformed value are
// flagged and left untouched.
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   start               one-cycle run request (ignored unless idle)
//   busy / done         run in progress / one-cycle end-of-run pulse
//   conflict, used_mask run result, held until the next accepted start
//   cell_sel, cell_address, cell_we, cell_wdata  cell bus command
//   cell_rdata          combinational read data from the selected cell
module sudoku_group_pruner
    import sudoku_group_pruner_pkg::*;
#(
    parameter int N_CELLS      = 9,
    parameter int IDX_W        = 4,
    parameter int WRITE_SOLVED = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             conflict,
    output logic [9:1]       used_mask,
    output logic [IDX_W-1:0] cell_sel,
    output logic             cell_address,
    output logic             cell_we,
    output logic [9:1]       cell_wdata,
    input  logic [9:1]       cell_rdata
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [9:1]         seen_q, seen_d;
    logic               bad_q, bad_d;
    logic [N_CELLS-1:0] solved_q, solved_d;
    logic               conflict_q, conflict_d;
    logic [9:1]         used_q, used_d;

    logic rd_zero_s;
    logic rd_onehot_s;

    sudoku_onehot_check u_onehot (
        .value_i     (cell_rdata),
        .is_zero_o   (rd_zero_s),
        .is_onehot_o (rd_onehot_s)
    );

    // Next-state logic for the read/write sequencer and result capture.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seen_d     = seen_q;
        bad_d      = bad_q;
        solved_d   = solved_q;
        conflict_d = conflict_q;
        used_d     = used_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_READ;
                    idx_d      = {IDX_W{1'b0}};
                    seen_d     = 9'd0;
                    bad_d      = 1'b0;
                    solved_d   = {N_CELLS{1'b0}};
                    conflict_d = 1'b0;
                    used_d     = 9'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                // A nonzero value is bad if malformed or if its digit is already used.
                if (!rd_zero_s && (!rd_onehot_s || ((cell_rdata & seen_q) != 9'd0))) begin
                    bad_d = 1'b1;
                end else begin
                    bad_d = bad_q;
                end
                seen_d          = seen_q | cell_rdata;
                solved_d[idx_q] = !rd_zero_s;
                if (idx_q == LAST_IDX) begin
                    idx_d = {IDX_W{1'b0}};
                    // bad_d already includes the final sample.
                    if (bad_d) begin
                        state_d    = ST_FIN;
                        conflict_d = 1'b1;
                        used_d     = seen_d;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d    = ST_FIN;
                    idx_d      = {IDX_W{1'b0}};
                    conflict_d = bad_q;
                    used_d     = seen_q;
                end else begin
                    idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= {IDX_W{1'b0}};
            seen_q     <= 9'd0;
            bad_q      <= 1'b0;
            solved_q   <= {N_CELLS{1'b0}};
            conflict_q <= 1'b0;
            used_q     <= 9'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seen_q     <= seen_d;
            bad_q      <= bad_d;
            solved_q   <= solved_d;
            conflict_q <= conflict_d;
            used_q     <= used_d;
        end
    end

    // Outputs are decoded purely from registered state.
    assign busy         = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign done         = (state_q == ST_FIN);
    assign conflict     = conflict_q;
    assign used_mask    = used_q;
    assign cell_sel     = idx_q;
    assign cell_address = (state_q == ST_WRITE) ? CELL_ADDR_VALID : CELL_ADDR_VALUE;
    assign cell_we      = (state_q == ST_WRITE) && ((WRITE_SOLVED != 0) || !solved_q[idx_q]);
    assign cell_wdata   = (state_q == ST_WRITE) ? (~seen_q & DIGIT_MASK_ALL) : 9'd0;

endmodule

// File: tb/tb_sudoku_group_pruner.sv
module tb_sudoku_group_pruner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start_drv;
    logic       use_b;
    logic [9:1] val [9];

    int checks = 0;
    int errors = 0;

    logic       a_start, a_busy, a_done, a_conflict, a_addr, a_we;
    logic [9:1] a_used, a_wdata, a_rdata;
    logic [3:0] a_sel;
    logic       b_start, b_busy, b_done, b_conflict, b_addr, b_we;
    logic [9:1] b_used, b_wdata, b_rdata;
    logic [3:0] b_sel;

    assign a_start = start_drv & ~use_b;
    assign b_start = start_drv & use_b;

    sudoku_group_pruner #(.N_CELLS(9), .IDX_W(4), .WRITE_SOLVED(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .busy(a_busy), .done(a_done),
        .conflict(a_conflict), .used_mask(a_used), .cell_sel(a_sel), .cell_address(a_addr),
        .cell_we(a_we), .cell_wdata(a_wdata), .cell_rdata(a_rdata)
    );

    sudoku_group_pruner #(.N_CELLS(9), .IDX_W(4), .WRITE_SOLVED(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .busy(b_busy), .done(b_done),
        .conflict(b_conflict), .used_mask(b_used), .cell_sel(b_sel), .cell_address(b_addr),
        .cell_we(b_we), .cell_wdata(b_wdata), .cell_rdata(b_rdata)
    );

    // Cell array model: value registers only are readable by the pruner.
    always_comb begin
        a_rdata = 9'd0;
        b_rdata = 9'd0;
        if (a_addr == 1'b0 && a_sel < 4'd9) a_rdata = val[a_sel];
        if (b_addr == 1'b0 && b_sel < 4'd9) b_rdata = val[b_sel];
    end

    // View of whichever instance is under test.
    logic       m_busy, m_done, m_conflict, m_addr, m_we;
    logic [9:1] m_used, m_wdata;
    logic [3:0] m_sel;
    assign m_busy     = use_b ? b_busy     : a_busy;
    assign m_done     = use_b ? b_done     : a_done;
    assign m_conflict = use_b ? b_conflict : a_conflict;
    assign m_addr     = use_b ? b_addr     : a_addr;
    assign m_we       = use_b ? b_we       : a_we;
    assign m_used     = use_b ? b_used     : a_used;
    assign m_wdata    = use_b ? b_wdata    : a_wdata;
    assign m_sel      = use_b ? b_sel      : a_sel;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Runs one group on the selected instance and checks it against a
    // set-based model: used digits, duplicates/malformed values, latency.
    task automatic run_group(input string name, input int inj_k, input bit fin_pulse, input int rst_k);
        logic [9:1] exp_seen;
        logic [9:1] exp_mask;
        bit         exp_bad;
        int         digit_cnt [10];
        int         exp_lat, exp_writes, n_writes, n_done, done_k;
        bit         exp_we;
        int         widx;

        exp_seen = 9'd0;
        exp_bad  = 1'b0;
        for (int d = 0; d < 10; d++) digit_cnt[d] = 0;
        for (int i = 0; i < 9; i++) begin
            exp_seen = exp_seen | val[i];
            if (val[i] != 9'd0 && $countones(val[i]) != 1) exp_bad = 1'b1;
            for (int d = 1; d <= 9; d++) if (val[i][d]) digit_cnt[d]++;
        end
        for (int d = 1; d <= 9; d++) if (digit_cnt[d] > 1) exp_bad = 1'b1;
        exp_mask   = ~exp_seen;
        exp_lat    = exp_bad ? 10 : 19;
        exp_writes = 0;
        if (!exp_bad) begin
            for (int i = 0; i < 9; i++) if (!(use_b && val[i] != 9'd0)) exp_writes++;
        end

        n_writes = 0;
        n_done   = 0;
        done_k   = -1;
        @(negedge clk);
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (rst_k >= 0 && k == rst_k + 1) begin
                check_eq({name, ".rst"}, {29'd0, m_busy, m_done, m_we}, 32'd0);
                reset_n = 1'b1;
                return;
            end
            if (k == 1) check_eq({name, ".clr"}, {22'd0, m_conflict, m_used}, 32'd0);
            if (k <= 9) begin
                check_eq({name, ".rd"}, {16'd0, m_busy, m_we, m_addr, m_sel, 9'd0},
                         {16'd0, 1'b1, 1'b0, 1'b0, 4'(k - 1), 9'd0});
            end else if (!exp_bad && k <= 18) begin
                widx   = k - 10;
                exp_we = !(use_b && val[widx] != 9'd0);
                check_eq({name, ".wr"}, {16'd0, m_busy, m_we, m_addr, m_sel, m_wdata},
                         {16'd0, 1'b1, exp_we, 1'b1, 4'(widx), exp_mask});
            end
            if (m_we) n_writes++;
            if (m_done) begin
                n_done++;
                if (n_done == 1) begin
                    done_k = k;
                    check_eq({name, ".res"}, {21'd0, m_busy, m_conflict, m_used},
                             {21'd0, 1'b0, exp_bad, exp_seen});
                end
            end
            if (k == exp_lat + 3) check_eq({name, ".idle"}, {31'd0, m_busy}, 32'd0);
            start_drv = (k == inj_k) || (fin_pulse && m_done);
            reset_n   = !(k == rst_k);
            @(negedge clk);
        end
        start_drv = 1'b0;
        check_eq({name, ".ndone"}, n_done, 1);
        check_eq({name, ".lat"}, done_k, exp_lat);
        check_eq({name, ".nwr"}, n_writes, exp_writes);
        check_eq({name, ".hold"}, {22'd0, m_conflict, m_used}, {22'd0, exp_bad, exp_seen});
    endtask

    function automatic logic [9:1] digit(input int d);
        logic [9:1] one;
        one = 9'd1;
        return one << (d - 1);
    endfunction

    task automatic set_row(input logic [9:1] v0, v1, v2, v3, v4, v5, v6, v7, v8);
        val[0] = v0; val[1] = v1; val[2] = v2; val[3] = v3; val[4] = v4;
        val[5] = v5; val[6] = v6; val[7] = v7; val[8] = v8;
    endtask

    initial begin
        int perm [9];
        int j, t, mode, i2, j2;

        reset_n   = 1'b0;
        start_drv = 1'b0;
        use_b     = 1'b0;
        for (int i = 0; i < 9; i++) val[i] = 9'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_a", {9'd0, a_busy, a_done, a_conflict, a_we, a_addr, a_sel, a_used, a_wdata}, 32'd0);
        check_eq("reset_b", {9'd0, b_busy, b_done, b_conflict, b_we, b_addr, b_sel, b_used, b_wdata}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        set_row(9'h001, 9'h000, 9'h004, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h100);
        run_group("row", -1, 1'b0, -1);
        set_row(9'h000, 9'h000, 9'h010, 9'h000, 9'h000, 9'h000, 9'h000, 9'h010, 9'h000);
        run_group("dup", -1, 1'b0, -1);
        set_row(9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h003);
        run_group("malf", -1, 1'b0, -1);
        set_row(9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000);
        run_group("empty", -1, 1'b0, -1);
        set_row(9'h1FF & 9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h080, 9'h100);
        run_group("full", -1, 1'b0, -1);
        use_b = 1'b1;
        set_row(9'h000, 9'h000, 9'h000, 9'h000, 9'h020, 9'h000, 9'h000, 9'h000, 9'h000);
        run_group("solved0", -1, 1'b0, -1);
        use_b = 1'b0;
        set_row(9'h001, 9'h000, 9'h004, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h100);
        run_group("ignore", 4, 1'b1, -1);
        run_group("midrst", -1, 1'b0, 13);
        repeat (2) @(negedge clk);
        run_group("after_rst", -1, 1'b0, -1);

        // Randomized groups: mostly legal, some duplicates or malformed values.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 9; i++) perm[i] = i + 1;
            for (int i = 8; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            for (int i = 0; i < 9; i++) val[i] = ($urandom_range(0, 2) == 0) ? 9'd0 : digit(perm[i]);
            mode = $urandom_range(0, 5);
            if (mode == 0) begin
                i2 = $urandom_range(0, 8);
                j2 = (i2 + $urandom_range(1, 8)) % 9;
                val[j2] = digit($urandom_range(1, 9));
                val[i2] = val[j2];
            end else if (mode == 1) begin
                i2 = $urandom_range(0, 8);
                val[i2] = digit($urandom_range(1, 9)) | digit($urandom_range(1, 9)) | 9'(1 << $urandom_range(0, 8));
            end else begin
                i2 = 0;
            end
            use_b = $urandom_range(0, 1) == 1;
            run_group("rand", ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : -1,
                      $urandom_range(0, 1) == 1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
